memory_byte_fetcher: RTL and testbench

//  Upstream stage of the 32-bit data register: sequences byte-wide memory reads and assembles 1/2/4-byte operands into one 32-bit word.

---
 rtl/memory_byte_fetcher_pkg.sv | 27 ++
 rtl/memory_byte_fetcher_byte_extender.sv | 28 ++
 rtl/memory_byte_fetcher.sv | 123 ++++++++++++
 tb/tb_memory_byte_fetcher.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_byte_fetcher_pkg.sv
// ----------------------------------------------------------------------------
// memory_byte_fetcher_pkg
//   Shared definitions for the byte fetcher: FSM state encoding, operand size
//   codes and a helper that turns a size code into a byte count.
// ----------------------------------------------------------------------------
package memory_byte_fetcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 11 is treated as a word, same as 10.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_byte_fetcher_byte_extender.sv
// ----------------------------------------------------------------------------
// memory_byte_fetcher_byte_extender
//   Combinational sign/zero extension of the assembled accumulator.
//   Ports:
//     acc_i    [31:0] shift accumulator, newest byte in bits [7:0]
//     count_i  [2:0]  operand length in bytes (1, 2 or 4)
//     sign_i          1 = sign-extend short operands, 0 = zero-extend
//     word_o   [31:0] extended 32-bit result
// ----------------------------------------------------------------------------
module memory_byte_fetcher_byte_extender
    import memory_byte_fetcher_pkg::*;
(
    input  logic [31:0] acc_i,
    input  logic [2:0]  count_i,
    input  logic        sign_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = acc_i;
        case (count_i)
            3'd1:    word_o = {{24{sign_i & acc_i[7]}},  acc_i[7:0]};
            3'd2:    word_o = {{16{sign_i & acc_i[15]}}, acc_i[15:0]};
            default: word_o = acc_i;
        endcase
    end

endmodule

// File: rtl/memory_byte_fetcher.sv
// ----------------------------------------------------------------------------
// memory_byte_fetcher
//   Sequences 1/2/4 byte-wide memory reads (big-endian) and presents a single
//   extended 32-bit word to the downstream data register.
//   Ports:
//     clk_i        system clock, rising edge
//     rst_ni       asynchronous active-low reset
//     start_i      fetch request, sampled in IDLE only
//     addr_i       base byte address, captured with start_i
//     size_i       00 byte, 01 half, 1x word, captured with start_i
//     sign_i       sign-extend short results, captured with start_i
//     mem_req_o    read request (high throughout FETCH)
//     mem_addr_o   byte address being read
//     mem_ack_i    mem_data_i valid this cycle
//     mem_data_i   read byte
//     busy_o       high while in FETCH
//     done_o       one-cycle completion pulse
//     data_out_o   assembled word, held until the next accepted start
// ----------------------------------------------------------------------------
module memory_byte_fetcher
    import memory_byte_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [7:0]            mem_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           data_out_o
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [31:0]           acc_q,   acc_d;
    logic [2:0]            cnt_q,   cnt_d;
    logic [2:0]            len_q,   len_d;
    logic                  sign_q,  sign_d;
    logic [31:0]           data_q,  data_d;
    logic [31:0]           ext_word;

    // Extension is applied to the next-state accumulator so the final byte
    // is included in the word registered on the edge entering DONE.
    memory_byte_fetcher_byte_extender u_ext (
        .acc_i   (acc_d),
        .count_i (len_q),
        .sign_i  (sign_q),
        .word_o  (ext_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sign_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sign_d  = sign_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d  = addr_i;
                    len_d   = size_to_count(size_i);
                    sign_d  = sign_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ack_i) begin
                    acc_d  = {acc_q[23:0], mem_data_i};
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_d == len_q) begin
                        data_d  = ext_word;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req_o  = (state_q == ST_FETCH);
    assign busy_o     = (state_q == ST_FETCH);
    assign done_o     = (state_q == ST_DONE);
    assign mem_addr_o = addr_q;
    assign data_out_o = data_q;

endmodule

// File: tb/tb_memory_byte_fetcher.sv
module tb_memory_byte_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [15:0] addr_i;
    logic [1:0]  size_i;
    logic        sign_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_out_o;

    always #5 clk = ~clk;

    memory_byte_fetcher #(.ADDR_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .addr_i     (addr_i),
        .size_i     (size_i),
        .sign_i     (sign_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .data_out_o (data_out_o)
    );

    // Byte-addressed memory image served by the bench
    logic [7:0]  mem_model [0:65535];
    logic [31:0] prev_result;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected value from the byte sequence: big-endian integer, then
    // two's-complement reinterpretation for signed short operands.
    function automatic logic [31:0] ref_word(input longint raw, input int n, input bit s);
        longint v;
        v = raw;
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic do_fetch(input logic [15:0] a, input logic [1:0] sz, input bit s,
                            input int minw, input int maxw,
                            input bit poke_fetch, input bit poke_done);
        int          n;
        int          w;
        longint      raw;
        logic [15:0] ea;
        logic [31:0] exp;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        raw = 0;
        start_i   = 1'b1;
        addr_i    = a;
        size_i    = sz;
        sign_i    = s;
        mem_ack_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        addr_i  = 16'($urandom);
        size_i  = 2'($urandom);
        sign_i  = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            ea = a + 16'(i);
            w  = $urandom_range(maxw, minw);
            for (int k = 0; k <= w; k++) begin
                check_eq("busy", 32'(busy_o), 32'd1);
                check_eq("mem_req", 32'(mem_req_o), 32'd1);
                check_eq("done_in_fetch", 32'(done_o), 32'd0);
                check_eq("mem_addr", 32'(mem_addr_o), 32'(ea));
                check_eq("data_hold", data_out_o, prev_result);
                if (poke_fetch && i == 1 && k == 0) begin
                    start_i = 1'b1;
                    addr_i  = ~a;
                end else begin
                    start_i = 1'b0;
                end
                if (k == w) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_model[ea];
                    raw = raw * 256 + longint'(mem_model[ea]);
                end else begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        exp       = ref_word(raw, n, s);
        mem_ack_i = 1'($urandom);
        start_i   = poke_done;
        check_eq("done", 32'(done_o), 32'd1);
        check_eq("busy_done", 32'(busy_o), 32'd0);
        check_eq("mem_req_done", 32'(mem_req_o), 32'd0);
        check_eq("data_out", data_out_o, exp);
        @(negedge clk);
        start_i   = 1'b0;
        mem_ack_i = 1'b0;
        check_eq("done_width", 32'(done_o), 32'd0);
        check_eq("busy_idle", 32'(busy_o), 32'd0);
        check_eq("data_keep", data_out_o, exp);
        prev_result = exp;
        $display("fetch addr=%04h size=%0d sign=%0d -> %08h (expect %08h)", a, n, s, data_out_o, exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
        prev_result = 32'h0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        addr_i     = 16'h0;
        size_i     = 2'b00;
        sign_i     = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 8'h5A;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check_eq("rst_data", data_out_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // MemAck while idle must not start anything
        check_eq("idle_ack_busy", 32'(busy_o), 32'd0);
        mem_ack_i = 1'b0;

        // 1. word fetch crossing a page
        mem_model[16'h00FE] = 8'h11; mem_model[16'h00FF] = 8'h22;
        mem_model[16'h0100] = 8'h33; mem_model[16'h0101] = 8'h44;
        do_fetch(16'h00FE, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("t1_word", data_out_o, 32'h11223344);

        // 2. address wrap
        mem_model[16'hFFFF] = 8'hAB; mem_model[16'h0000] = 8'hCD;
        do_fetch(16'hFFFF, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("t2_wrap", data_out_o, 32'h0000ABCD);

        // 3. byte sign/zero extension
        mem_model[16'h1234] = 8'h80;
        do_fetch(16'h1234, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0);
        check_eq("t3_sext", data_out_o, 32'hFFFFFF80);
        do_fetch(16'h1234, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("t3_zext", data_out_o, 32'h00000080);

        // 4. waits before each ack
        mem_model[16'h2000] = 8'h9A; mem_model[16'h2001] = 8'h01;
        do_fetch(16'h2000, 2'b01, 1'b1, 3, 3, 1'b0, 1'b0);
        check_eq("t4_wait", data_out_o, 32'hFFFF9A01);

        // 5. Start during FETCH and during DONE ignored
        do_fetch(16'h3000, 2'b11, 1'b0, 0, 1, 1'b1, 1'b1);

        // 6. reset after two bytes of a word fetch
        start_i = 1'b1; addr_i = 16'h4000; size_i = 2'b10; sign_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 8'hEE;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_data", data_out_o, 32'd0);
        check_eq("mid_rst_done", 32'(done_o), 32'd0);
        mem_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_result = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_done", 32'(done_o), 32'd0);
            check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        end
        mem_model[16'h5000] = 8'hCA; mem_model[16'h5001] = 8'hFE;
        mem_model[16'h5002] = 8'hBA; mem_model[16'h5003] = 8'hBE;
        do_fetch(16'h5000, 2'b10, 1'b1, 0, 1, 1'b0, 1'b0);
        check_eq("t6_after_rst", data_out_o, 32'hCAFEBABE);

        // randomized fetches, some back-to-back, some near the wrap point
        for (int t = 0; t < 60; t++) begin
            logic [15:0] ra;
            ra = ($urandom_range(3, 0) == 0) ? 16'(16'hFFFC + 16'($urandom_range(3, 0)))
                                             : 16'($urandom);
            do_fetch(ra, 2'($urandom), 1'($urandom), 0, 2,
                     1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(3, 1)) begin
                    mem_ack_i = 1'($urandom);
                    @(negedge clk);
                    check_eq("idle_busy", 32'(busy_o), 32'd0);
                    check_eq("idle_data", data_out_o, prev_result);
                end
                mem_ack_i = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
